// File: rtl/rv_mem_pkg.sv
// Shared definitions for the load/store unit: func3 encodings, FSM states and
// byte-lane helpers.
package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitR,
    StDone
  } lsu_state_t;

  // Lane mask for an access of the size encoded in func3[1:0] at byte offset off.
  function automatic logic [3:0] byte_enable(input logic [2:0] func3, input logic [1:0] off);
    logic [3:0] be;
    case (func3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic access_legal(input logic is_store, input logic [2:0] func3,
                                        input logic [1:0] off);
    logic ok;
    case (func3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = !off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = !is_store;
      F3_HU:   ok = !is_store && !off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed lane of a read word and sign/zero-extends it per func3.
module load_extend
  import rv_mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_func3,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_off, 3'b000};

  always_comb begin
    case (i_func3)
      F3_B:    o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_BU:   o_data = {24'd0, w_shifted[7:0]};
      F3_HU:   o_data = {16'd0, w_shifted[15:0]};
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: single-outstanding req/gnt/rvalid bus master producing the
// register-file writeback and stalling upstream while an access is in flight.
module load_store_unit
  import rv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [31:0]       i_alu_result,
  input  logic [31:0]       i_rd2,
  input  logic [4:0]        i_rd,
  input  logic [2:0]        i_func3,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic              i_mem_to_reg,
  input  logic              i_reg_write,
  output logic              o_stall,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [3:0]        o_mem_be,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [31:0]       i_mem_rdata,
  output logic [31:0]       o_wd,
  output logic [4:0]        o_wb_rd,
  output logic              o_wb_we,
  output logic              o_access_err
);

  lsu_state_t        r_state, w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_off;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic              r_we;
  logic [4:0]        r_rd;
  logic [2:0]        r_func3;
  logic [31:0]       r_wd;
  logic [4:0]        r_wb_rd;
  logic              r_wb_we;
  logic              r_err;

  logic              w_access;
  logic              w_legal;
  logic [1:0]        w_off;
  logic [31:0]       w_wdata;
  logic [31:0]       w_ext;

  assign w_access = i_mem_read | i_mem_write;
  assign w_off    = i_alu_result[1:0];
  // A set mem_write wins over mem_read, so legality is judged as a store.
  assign w_legal  = access_legal(i_mem_write, i_func3, w_off);

  always_comb begin
    case (i_func3[1:0])
      2'b00:   w_wdata = {4{i_rd2[7:0]}};
      2'b01:   w_wdata = {2{i_rd2[15:0]}};
      default: w_wdata = i_rd2;
    endcase
  end

  load_extend u_load_extend (
    .i_rdata (i_mem_rdata),
    .i_off   (r_off),
    .i_func3 (r_func3),
    .o_data  (w_ext)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= StIdle;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_access) w_state_next = w_legal ? StReq : StDone;
      StReq:   if (i_mem_gnt) w_state_next = r_we ? StDone : StWaitR;
      StWaitR: if (i_mem_rvalid) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    o_stall   = 1'b0;
    o_mem_req = 1'b0;
    o_mem_we  = 1'b0;
    case (r_state)
      StIdle:  o_stall = w_access;
      StReq: begin
        o_stall   = 1'b1;
        o_mem_req = 1'b1;
        o_mem_we  = r_we;
      end
      StWaitR: o_stall = 1'b1;
      default: o_stall = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr  <= '0;
      r_off   <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_rd    <= '0;
      r_func3 <= '0;
      r_wd    <= '0;
      r_wb_rd <= '0;
      r_wb_we <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (!w_access) begin
            r_wd    <= i_alu_result;
            r_wb_rd <= i_rd;
            r_wb_we <= i_reg_write;
          end else begin
            r_wb_we <= 1'b0;
            r_wb_rd <= i_rd;
            if (w_legal) begin
              r_addr  <= {i_alu_result[ADDR_W-1:2], 2'b00};
              r_off   <= w_off;
              r_be    <= byte_enable(i_func3, w_off);
              r_wdata <= w_wdata;
              r_we    <= i_mem_write;
              r_rd    <= i_rd;
              r_func3 <= i_func3;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        StReq: r_wb_we <= 1'b0;
        // Upstream holds its inputs while stalled, so mem_to_reg/reg_write are still valid.
        StWaitR: begin
          if (i_mem_rvalid) begin
            r_wd    <= i_mem_to_reg ? w_ext : i_alu_result;
            r_wb_rd <= r_rd;
            r_wb_we <= i_reg_write;
          end
        end
        default: begin
          r_wb_we <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  assign o_mem_addr   = r_addr;
  assign o_mem_be     = r_be;
  assign o_mem_wdata  = r_wdata;
  assign o_wd         = r_wd;
  assign o_wb_rd      = r_wb_rd;
  assign o_wb_we      = r_wb_we;
  assign o_access_err = r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized bench for load_store_unit with a cycle-level reference
// schedule derived from access size, alignment and bus wait states.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_result, rd2, mem_rdata, mem_wdata, wd, mem_addr;
  logic [4:0]  rd, wb_rd;
  logic [2:0]  func3;
  logic        mem_read, mem_write, mem_to_reg, reg_write;
  logic        stall, mem_req, mem_we, mem_gnt, mem_rvalid, wb_we, access_err;
  logic [3:0]  mem_be;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_alu_result (alu_result),
    .i_rd2        (rd2),
    .i_rd         (rd),
    .i_func3      (func3),
    .i_mem_read   (mem_read),
    .i_mem_write  (mem_write),
    .i_mem_to_reg (mem_to_reg),
    .i_reg_write  (reg_write),
    .o_stall      (stall),
    .o_mem_req    (mem_req),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_be     (mem_be),
    .o_mem_wdata  (mem_wdata),
    .i_mem_gnt    (mem_gnt),
    .i_mem_rvalid (mem_rvalid),
    .i_mem_rdata  (mem_rdata),
    .o_wd         (wd),
    .o_wb_rd      (wb_rd),
    .o_wb_we      (wb_we),
    .o_access_err (access_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  task automatic pass_through(input logic [31:0] a, input logic [4:0] r, input logic rw);
    nop();
    alu_result = a;
    rd         = r;
    reg_write  = rw;
    #2;
    chk("pt_stall", stall, 0);
    tick();
    chk("pt_wd", wd, a);
    chk("pt_wb_rd", wb_rd, r);
    chk("pt_wb_we", wb_we, rw);
  endtask

  // Expected behaviour comes from size/alignment arithmetic and a wait-state schedule.
  task automatic run_access(input string tag, input logic rd_en, input logic wr_en,
                            input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] data2, input logic [4:0] rdst,
                            input logic regw, input logic m2r, input int gd, input int rvd,
                            input logic [31:0] rdata);
    bit          store;
    bit          legal;
    int          size;
    int          off;
    longint      v;
    logic [31:0] be, wdat, exp_wd;
    store = wr_en;
    size  = 1 << f3[1:0];
    off   = int'(addr % 4);
    legal = store ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    legal = legal && (off % size == 0);
    be    = ((32'd1 << size) - 32'd1) << off;
    wdat  = (size == 1) ? data2[7:0] * 32'h0101_0101 :
            (size == 2) ? data2[15:0] * 32'h0001_0001 : data2;
    v = longint'((rdata >> (8 * off))) & ((64'sd1 <<< (8 * size)) - 64'sd1);
    if (!f3[2] && size < 4 && v >= (64'sd1 <<< (8 * size - 1))) v = v - (64'sd1 <<< (8 * size));
    exp_wd = m2r ? v[31:0] : addr;

    nop();
    alu_result = addr;
    rd2        = data2;
    rd         = rdst;
    func3      = f3;
    mem_read   = rd_en;
    mem_write  = wr_en;
    mem_to_reg = m2r;
    reg_write  = regw;
    #2;
    chk({tag, "_c0_stall"}, stall, 1);
    chk({tag, "_c0_req"}, mem_req, 0);
    if (!legal) begin
      tick();
      #2;
      chk({tag, "_err_stall"}, stall, 0);
      chk({tag, "_err_pulse"}, access_err, 1);
      chk({tag, "_err_wb_we"}, wb_we, 0);
      chk({tag, "_err_req"}, mem_req, 0);
    end else begin
      for (int i = 0; i <= gd; i++) begin
        tick();
        mem_gnt    = (i == gd);
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom;
        #2;
        chk({tag, "_req"}, mem_req, 1);
        chk({tag, "_req_stall"}, stall, 1);
        chk({tag, "_req_we"}, mem_we, store);
        chk({tag, "_req_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
        chk({tag, "_req_be"}, mem_be, be);
        chk({tag, "_req_wdata"}, mem_wdata, wdat);
        chk({tag, "_req_wb_we"}, wb_we, 0);
      end
      if (!store) begin
        for (int i = 0; i <= rvd; i++) begin
          tick();
          mem_gnt    = 1'($urandom_range(0, 1));
          mem_rvalid = (i == rvd);
          mem_rdata  = (i == rvd) ? rdata : $urandom;
          #2;
          chk({tag, "_wait_req"}, mem_req, 0);
          chk({tag, "_wait_stall"}, stall, 1);
          chk({tag, "_wait_wb_we"}, wb_we, 0);
        end
      end
      tick();
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      #2;
      chk({tag, "_done_stall"}, stall, 0);
      chk({tag, "_done_req"}, mem_req, 0);
      chk({tag, "_done_err"}, access_err, 0);
      chk({tag, "_done_wb_we"}, wb_we, regw && !store);
      chk({tag, "_done_wb_rd"}, wb_rd, rdst);
      if (!store) chk({tag, "_done_wd"}, wd, exp_wd);
    end
    tick();
    nop();
    #2;
    chk({tag, "_post_wb_we"}, wb_we, 0);
    chk({tag, "_post_err"}, access_err, 0);
    chk({tag, "_post_stall"}, stall, 0);
  endtask

  initial begin
    reset      = 1'b1;
    alu_result = '0;
    rd2        = '0;
    rd         = '0;
    func3      = '0;
    mem_rdata  = '0;
    nop();
    tick();
    tick();
    chk("rst_wd", wd, 0);
    chk("rst_wb_we", wb_we, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_err", access_err, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_stall", stall, 0);
    reset = 1'b0;

    pass_through(32'd17, 5'd5, 1'b1);

    run_access("lb", 1, 0, 3'b000, 32'h103, 32'h0, 5'd7, 1, 1, 0, 0, 32'h80FF_0000);
    run_access("sh", 0, 1, 3'b001, 32'h202, 32'h1234_ABCD, 5'd9, 1, 0, 3, 0, 32'h0);
    run_access("lw_mis", 1, 0, 3'b010, 32'h101, 32'h0, 5'd3, 1, 1, 0, 0, 32'h0);
    run_access("ld_f3_3", 1, 0, 3'b011, 32'h100, 32'h0, 5'd3, 1, 1, 0, 0, 32'h0);
    run_access("lhu", 1, 0, 3'b101, 32'h2, 32'h0, 5'd11, 1, 1, 0, 5, 32'hBEEF_1234);
    run_access("both_sw", 1, 1, 3'b010, 32'h40, 32'hCAFE_F00D, 5'd1, 1, 1, 1, 0, 32'h0);

    // Reset while a load sits in REQ; the bus answers late and must be ignored.
    nop();
    alu_result = 32'h300;
    func3      = 3'b010;
    mem_read   = 1'b1;
    reg_write  = 1'b1;
    mem_to_reg = 1'b1;
    tick();
    #2;
    chk("mid_req", mem_req, 1);
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    nop();
    alu_result = '0;
    rd         = '0;
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    #2;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_wb_we", wb_we, 0);
    chk("mid_rst_wd", wd, 0);
    chk("mid_rst_be", mem_be, 0);
    chk("mid_rst_addr", mem_addr, 0);
    tick();
    #2;
    chk("late_req", mem_req, 0);
    chk("late_wd", wd, 0);
    chk("late_wb_we", wb_we, 0);
    chk("late_err", access_err, 0);
    nop();

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        pass_through($urandom, 5'($urandom), 1'($urandom));
      end else begin
        int unsigned op;
        op = $urandom_range(1, 3);
        run_access("rnd", op[0], op[1], 3'($urandom), $urandom, $urandom, 5'($urandom),
                   1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), $urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage directly downstream of `top_stage`. It consumes the ALU result, store data and decode controls, then runs loads and stores over a single-outstanding request/grant/rvalid data bus. It produces the register-file writeback (`wd`, destination, write enable) and stalls the upstream stage while an access is in flight. Non-memory instructions pass through with one cycle of latency.

## Interface
Parameters:
- `ADDR_W`, default 32: byte-address width of `alu_result`/`mem_addr`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `alu_result`  in  32  effective address for loads/stores; writeback value otherwise.
- `rd2`  in  32  store data.
- `rd`  in  5  destination register.
- `func3`  in  3  access size and sign.
- `mem_read`, `mem_write`, `mem_to_reg`, `reg_write`  in  1 each  controls from the decoder.
- `stall`  out  1  upstream must hold all inputs while high.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  store request.
- `mem_addr`  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2], 2'b00}.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_gnt`  in  1  request accepted this cycle.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  32  read word.
- `wd`  out  32  writeback data.
- `wb_rd`  out  5  writeback register.
- `wb_we`  out  1  writeback enable.
- `access_err`  out  1  one-cycle pulse on misaligned access or illegal func3.

## Operation
- Reset: sync, active-high. FSM→IDLE; `wd`, `wb_rd`, `wb_we`, `access_err`, `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata` all 0.
- FSM states: IDLE, REQ, WAIT_R, DONE.
- IDLE, no access (`mem_read`=`mem_write`=0):
  - `stall`=0.
  - Next edge: `wd`<=`alu_result`, `wb_rd`<=`rd`, `wb_we`<=`reg_write`.
  - State stays IDLE.
- IDLE, access present:
  - `stall`=1, combinational.
  - If both `mem_read` and `mem_write` are set, the store takes priority.
  - Legal access: latch addr/be/wdata/we/rd/func3, go to REQ, `wb_we`<=0.
  - Illegal access: go to DONE with `access_err`=1 and `wb_we`=0. No bus transaction is issued.
- Legality:
  - Loads: func3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other func3 is illegal.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
- Byte enables:
  - Byte: 4'b0001<<addr[1:0].
  - Half: 4'b0011<<addr[1:0].
  - Word: 4'b1111.
- Store data: byte {4{rd2[7:0]}}; half {2{rd2[15:0]}}; word rd2.
- REQ:
  - `mem_req`=1, with addr/we/be/wdata stable until `mem_gnt`.
  - On gnt: store→DONE; load→WAIT_R.
  - `mem_rvalid` in REQ is ignored.
- WAIT_R: on `mem_rvalid`, select the lane by addr[1:0], sign/zero-extend per func3, latch into `wd`, go to DONE.
- DONE:
  - `stall`=0, so upstream advances on this edge.
  - Outputs valid this cycle: `wb_we`=`reg_write`&&load&&!err; `wb_rd`=latched rd.
  - Next state IDLE; `wb_we` and `access_err` clear.
- `mem_to_reg` selects load data vs `alu_result`. For stores, `wb_we`=0.
- Reset mid-access: returns to IDLE next edge and drops `mem_req`. A late gnt/rvalid is ignored.

## Timing
- Pass-through latency: 1 cycle.
- Load, gnt in the first REQ cycle, rvalid the next cycle: IDLE c0, REQ c1, WAIT_R c2, DONE c3. Writeback is visible in c3. 4 cycles minimum.
- Store minimum: 3 cycles (IDLE, REQ, DONE).
- Error access: 2 cycles (IDLE, DONE).
- Each additional gnt or rvalid wait cycle adds 1 cycle.
- At most one outstanding request. `mem_req` is never asserted outside REQ.

## Structure
- Package `rv_mem_pkg`:
  - func3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - `lsu_state_t` enum.
  - Byte-enable helper function.
- Sub-module `load_extend`: combinational; inputs rdata, addr[1:0], func3; output extended 32-bit value.

## Test plan
- Reset asserted mid-REQ → `mem_req`=0 next cycle, state IDLE, all outputs 0. Following gnt/rvalid ignored.
- Pass-through: `alu_result`=17, `rd`=5, `reg_write`=1 → next cycle `wd`=17, `wb_rd`=5, `wb_we`=1, `stall`=0.
- LB at addr 0x103, `mem_rdata`=0x80FF_0000, gnt in c1, rvalid in c2 → `mem_addr`=0x100, `mem_be`=4'b1000. DONE in c3 with `wd`=0xFFFF_FF80, `wb_we`=1.
- SH at addr 0x202, `rd2`=0x1234_ABCD, gnt delayed 3 cycles → `mem_be`=4'b1100, `mem_wdata`=0xABCD_ABCD, `mem_req` held 4 cycles, `wb_we`=0, `stall` low only in DONE.
- LW at addr 0x101 → no `mem_req`, `access_err` pulses 1 cycle, `wb_we`=0. Same result for func3=011 load.
- LHU at 0x2, rvalid stalled 5 cycles → `stall` high throughout; `wd`=zero-extended upper half.
